cp0_regfile: RTL and testbench
==============================

Name: cp0_regfile

Overview:
- Coprocessor-0 register file; the consumer of the M-stage exception decoder's is_except / except_type outputs.
- Commits exception state (EPC, Cause.ExcCode/BD, Status.EXL, BadVAddr) on exceptions and ERET.
- Services MTC0/MFC0 and runs the Count/Compare timer.
- Drives cp0_status, cp0_cause and cp0_epc back to the exception decoder, closing the loop.

Parameters:
- PRID_VAL, 32'h004C_0001, constant value returned for PRId (reg 15).
- CONFIG_VAL, 32'h8000_0000, constant value returned for Config (reg 16, sel 0).

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- we_i  in  1  MTC0 write enable (M stage).
- waddr_i  in  5  MTC0 destination register number.
- wdata_i  in  32  MTC0 write data.
- raddr_i  in  5  MFC0 source register number.
- rdata_o  out  32  MFC0 read data.
- int_i  in  6  external hardware interrupt lines.
- is_except_i  in  1  exception/ERET commit strobe from the decoder.
- except_type_i  in  32  decoder type code: 1, 4, 5, 8, 9, a, c, e (hex).
- pc_i  in  32  PC of the excepting M-stage instruction.
- is_in_delayslot_i  in  1  excepting instruction is in a branch delay slot.
- bad_addr_i  in  32  faulting address (PC for fetch AdEL, data address otherwise).
- status_o  out  32  Status register.
- cause_o  out  32  Cause register.
- epc_o  out  32  EPC register.
- badvaddr_o  out  32  BadVAddr register.
- count_o  out  32  Count register.
- compare_o  out  32  Compare register.
- timer_int_o  out  1  timer interrupt pending.

Behaviour:
- **Reset (async, resetn=0):**
  - Status = 32'h0040_0000 (BEV=1).
  - Cause, EPC, BadVAddr, Count, Compare = 0.
  - timer_int_o = 0; tick phase = 0.
  - rdata_o follows the reset register values.
- **Writable bit masks:**
  - Status: IM[15:8], EXL[1], IE[0]; BEV[22] reads 1; all other bits read 0.
  - Cause: only IP[9:8] is software-writable.
  - EPC, Count, Compare: full 32-bit writable.
  - BadVAddr, PRId, Config: read-only; MTC0 to them is ignored.
  - MTC0 to any unimplemented register is ignored; MFC0 from it returns 0.
- **Cause.IP[15:10]:**
  - Sampled every cycle from int_i; bit 15 = int_i[5] | timer_int_o.
  - One-cycle register latency from int_i to cause_o.
- **Timer:**
  - A 1-bit tick toggles every cycle; Count increments when tick==1, i.e. every 2 clocks.
  - Count wraps from FFFF_FFFF to 0.
  - timer_int_o sets on the cycle after Count==Compare with Compare!=0, and stays set.
  - MTC0 to Compare clears timer_int_o.
  - MTC0 to Count overrides a same-cycle increment; tick phase is unchanged.
- **Exception commit** (is_except_i=1, except_type_i ≠ e):
  - If Status.EXL==0:
    - EPC <= is_in_delayslot_i ? pc_i-4 : pc_i.
    - Cause.BD[31] <= is_in_delayslot_i.
  - If Status.EXL==1: EPC and BD are unchanged.
  - Always: Status.EXL <= 1; Cause.ExcCode[6:2] <= code, where type 1 maps to code 0 and all other types map to themselves.
  - For types 4 and 5: BadVAddr <= bad_addr_i.
- **ERET** (is_except_i=1, except_type_i=e): Status.EXL <= 0; nothing else changes.
- **Same-cycle conflict:** exception/ERET takes priority over MTC0 for every register, and the MTC0 is dropped (the instruction is flushed). Timer and IP sampling still proceed.
- **Read path:**
  - Combinational from the registers, with same-cycle bypass: we_i && waddr_i==raddr_i returns the masked wdata_i, unless is_except_i.
  - Status/Cause reads reflect read-only bit rules.
- Unknown except_type_i with is_except_i=1: no state change.

Optional Feature:
- Macro: CP0_TIMER_INT_EN.
- Defined: timer interrupt logic as above; timer interrupt feeds Cause.IP[15].
- Undefined:
  - timer_int_o tied 0; Cause.IP[15] = int_i[5] only.
  - Count and Compare remain readable, writable and counting.

Decomposition:
- Shared package/header (cp0_defs) holds:
  - Register numbers: BADVADDR 8, COUNT 9, COMPARE 11, STATUS 12, CAUSE 13, EPC 14, PRID 15, CONFIG 16.
  - Write masks and the Status reset value.
  - Except-type constants 1/4/5/8/9/a/c/e, shared with the exception decoder.
- One sub-module: cp0_timer (tick, Count, Compare, timer_int) with write ports for Count and Compare.

Test Plan:
- resetn low mid-run with Count=0x55 → all outputs return to their reset values immediately (async); status_o=0040_0000.
- Write Compare=0x10 (Count at 0) → timer_int_o rises on the cycle after count_o==0x10 (~32 clocks); cause_o[15]=1; MTC0 Compare=0x40 → timer_int_o=0 next cycle.
- Exception type 5, pc_i=BFC0_0100, bad_addr_i=0000_0003, delay slot=1:
  - epc_o=BFC0_00FC; cause_o[31]=1; cause_o[6:2]=5.
  - badvaddr_o=0000_0003; status_o[1]=1.
- With EXL=1, exception type 8 at pc_i=BFC0_0200 → epc_o unchanged; ExcCode=8. Then ERET → status_o[1]=0.
- Same cycle: MTC0 EPC=1234_5678 plus exception type c at pc_i=BFC0_0300 (EXL=0) → epc_o=BFC0_0300; write dropped.
- MTC0 Status=FFFF_FFFF → status_o=0040_FF03. MTC0 Cause=FFFF_FFFF → only cause_o[9:8]=2'b11. Same-cycle MFC0 Status → 0040_FF03.

Source files
------------

// File: rtl/cp0_regfile_pkg.sv
// cp0_regfile_pkg: shared CP0 definitions (register numbers, write masks,
//   reset values, exception type codes) used by the CP0 register file and
//   by the M-stage exception decoder.
// Ports: none (package).
package cp0_regfile_pkg;

  // CP0 register numbers (sel 0)
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam logic [4:0] REG_CONFIG   = 5'd16;

  // Software-writable bits and fixed values
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;  // IM[15:8], EXL, IE
  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;  // BEV=1, reads 1 always
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;  // IP[9:8]

  // Exception type codes produced by the decoder
  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000A;
  localparam logic [31:0] EXC_OV   = 32'h0000_000C;
  localparam logic [31:0] EXC_ERET = 32'h0000_000E;

  // True for a real exception (ERET and unknown codes excluded)
  function automatic logic is_exc_type(input logic [31:0] t);
    return (t == EXC_INT) || (t == EXC_ADEL) || (t == EXC_ADES) ||
           (t == EXC_SYS) || (t == EXC_BP)   || (t == EXC_RI)   ||
           (t == EXC_OV);
  endfunction

  // Cause.ExcCode for a type: interrupts encode as 0, the rest as themselves
  function automatic logic [4:0] exc_code(input logic [31:0] t);
    return (t == EXC_INT) ? 5'd0 : t[4:0];
  endfunction

endpackage

// File: rtl/cp0_regfile_if.sv
// cp0_regfile_if: pipeline <-> CP0 bus (MTC0/MFC0, interrupt lines,
//   exception commit inputs, architectural register outputs).
// Modports: master = pipeline/decoder side, slave = CP0 register file.
interface cp0_regfile_if;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [5:0]  int_i;
  logic        is_except_i;
  logic [31:0] except_type_i;
  logic [31:0] pc_i;
  logic        is_in_delayslot_i;
  logic [31:0] bad_addr_i;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic [31:0] badvaddr_o;
  logic [31:0] count_o;
  logic [31:0] compare_o;
  logic        timer_int_o;

  modport master (
    output we_i, waddr_i, wdata_i, raddr_i, int_i, is_except_i,
           except_type_i, pc_i, is_in_delayslot_i, bad_addr_i,
    input  rdata_o, status_o, cause_o, epc_o, badvaddr_o, count_o,
           compare_o, timer_int_o
  );

  modport slave (
    input  we_i, waddr_i, wdata_i, raddr_i, int_i, is_except_i,
           except_type_i, pc_i, is_in_delayslot_i, bad_addr_i,
    output rdata_o, status_o, cause_o, epc_o, badvaddr_o, count_o,
           compare_o, timer_int_o
  );
endinterface

// File: rtl/cp0_regfile_timer.sv
// cp0_timer: free-running Count (+1 every 2 clocks), Compare, and sticky
//   timer interrupt. Optional macro CP0_TIMER_INT_EN enables the interrupt;
//   without it o_timer_int is tied 0 while Count/Compare still work.
// Ports: clk, resetn; i_count_we/i_compare_we + i_wdata write ports;
//   o_count, o_compare, o_timer_int.
module cp0_timer (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_count_we,
  input  logic        i_compare_we,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_timer_int
);

  logic        r_tick;
  logic [31:0] r_count;
  logic [31:0] r_compare;

  // Tick phase runs regardless of Count writes so the divide-by-2 cadence
  // is never disturbed by software.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= ~r_tick;
    end
  end

  // A software write wins over the same-cycle increment.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= 32'd0;
    end else if (i_count_we) begin
      r_count <= i_wdata;
    end else if (r_tick) begin
      r_count <= r_count + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_compare <= 32'd0;
    end else if (i_compare_we) begin
      r_compare <= i_wdata;
    end
  end

`ifdef CP0_TIMER_INT_EN
  logic r_timer_int;

  // Compare==0 is treated as "timer disarmed"; writing Compare acknowledges.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_timer_int <= 1'b0;
    end else if (i_compare_we) begin
      r_timer_int <= 1'b0;
    end else if ((r_count == r_compare) && (r_compare != 32'd0)) begin
      r_timer_int <= 1'b1;
    end
  end

  assign o_timer_int = r_timer_int;
`else
  assign o_timer_int = 1'b0;
`endif

  assign o_count   = r_count;
  assign o_compare = r_compare;

endmodule

// File: rtl/cp0_regfile.sv
// cp0_regfile: MIPS CP0 register file - exception/ERET commit, MTC0/MFC0,
//   Count/Compare timer (cp0_timer). Optional macro CP0_TIMER_INT_EN.
// Ports: clk, resetn (async, active low); bus (cp0_regfile_if.slave) carries
//   MTC0/MFC0, int lines, exception commit inputs and register outputs.
module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter logic [31:0] PRID_VAL   = 32'h004C_0001,
  parameter logic [31:0] CONFIG_VAL = 32'h8000_0000
) (
  input logic           clk,
  input logic           resetn,
  cp0_regfile_if.slave  bus
);

  logic [31:0] r_status;
  logic        r_cause_bd;
  logic [5:0]  r_cause_ip_hw;
  logic [1:0]  r_cause_ip_sw;
  logic [4:0]  r_cause_exc;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;

  logic        w_exc;
  logic        w_eret;
  logic        w_mtc0;
  logic        w_byp;
  logic        w_timer_int;
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic [31:0] w_cause;

  assign w_exc  = bus.is_except_i && is_exc_type(bus.except_type_i);
  assign w_eret = bus.is_except_i && (bus.except_type_i == EXC_ERET);
  // Any commit strobe (even an unknown type) flushes the M-stage MTC0.
  assign w_mtc0 = bus.we_i && !bus.is_except_i;
  assign w_byp  = w_mtc0 && (bus.waddr_i == bus.raddr_i);

  cp0_timer u_timer (
    .clk          (clk),
    .resetn       (resetn),
    .i_count_we   (w_mtc0 && (bus.waddr_i == REG_COUNT)),
    .i_compare_we (w_mtc0 && (bus.waddr_i == REG_COMPARE)),
    .i_wdata      (bus.wdata_i),
    .o_count      (w_count),
    .o_compare    (w_compare),
    .o_timer_int  (w_timer_int)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_status <= STATUS_RESET;
    end else if (w_exc) begin
      r_status[1] <= 1'b1;
    end else if (w_eret) begin
      r_status[1] <= 1'b0;
    end else if (w_mtc0 && (bus.waddr_i == REG_STATUS)) begin
      r_status <= (bus.wdata_i & STATUS_WMASK) | STATUS_RESET;
    end
  end

  // Hardware IP bits are a plain one-cycle sample of the interrupt lines.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cause_ip_hw <= 6'd0;
    end else begin
      r_cause_ip_hw <= {bus.int_i[5] | w_timer_int, bus.int_i[4:0]};
    end
  end

  // BD and EPC are frozen while EXL is set (nested exception keeps the
  // original return point).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cause_bd    <= 1'b0;
      r_cause_ip_sw <= 2'd0;
      r_cause_exc   <= 5'd0;
      r_epc         <= 32'd0;
    end else if (w_exc) begin
      r_cause_exc <= exc_code(bus.except_type_i);
      if (!r_status[1]) begin
        r_cause_bd <= bus.is_in_delayslot_i;
        r_epc      <= bus.is_in_delayslot_i ? (bus.pc_i - 32'd4) : bus.pc_i;
      end
    end else if (w_mtc0 && (bus.waddr_i == REG_CAUSE)) begin
      r_cause_ip_sw <= bus.wdata_i[9:8];
    end else if (w_mtc0 && (bus.waddr_i == REG_EPC)) begin
      r_epc <= bus.wdata_i;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_badvaddr <= 32'd0;
    end else if (w_exc && ((bus.except_type_i == EXC_ADEL) ||
                           (bus.except_type_i == EXC_ADES))) begin
      r_badvaddr <= bus.bad_addr_i;
    end
  end

  assign w_cause = {r_cause_bd, 15'd0, r_cause_ip_hw, r_cause_ip_sw, 1'b0,
                    r_cause_exc, 2'b00};

  // MFC0 with same-cycle MTC0 bypass; read-only registers never bypass.
  always_comb begin
    bus.rdata_o = 32'd0;
    case (bus.raddr_i)
      REG_STATUS:   bus.rdata_o = w_byp ? ((bus.wdata_i & STATUS_WMASK) | STATUS_RESET)
                                        : r_status;
      REG_CAUSE:    bus.rdata_o = w_byp ? {w_cause[31:10], bus.wdata_i[9:8], w_cause[7:0]}
                                        : w_cause;
      REG_EPC:      bus.rdata_o = w_byp ? bus.wdata_i : r_epc;
      REG_COUNT:    bus.rdata_o = w_byp ? bus.wdata_i : w_count;
      REG_COMPARE:  bus.rdata_o = w_byp ? bus.wdata_i : w_compare;
      REG_BADVADDR: bus.rdata_o = r_badvaddr;
      REG_PRID:     bus.rdata_o = PRID_VAL;
      REG_CONFIG:   bus.rdata_o = CONFIG_VAL;
      default:      bus.rdata_o = 32'd0;
    endcase
  end

  assign bus.status_o    = r_status;
  assign bus.cause_o     = w_cause;
  assign bus.epc_o       = r_epc;
  assign bus.badvaddr_o  = r_badvaddr;
  assign bus.count_o     = w_count;
  assign bus.compare_o   = w_compare;
  assign bus.timer_int_o = w_timer_int;

endmodule

// File: tb/tb_cp0_regfile.sv
// tb_cp0_regfile: directed, table-driven bench for cp0_regfile plus hand
//   sequences for interrupt latency, async reset, timer and Count wrap.
// Ports: none (top-level bench).
module tb_cp0_regfile;
  import cp0_regfile_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  cp0_regfile_if bus ();

  cp0_regfile #(
    .PRID_VAL   (32'h004C_0001),
    .CONFIG_VAL (32'h8000_0000)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic        exc;
    logic [31:0] etype;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] bad;
    logic [31:0] e_rdata;
    logic [31:0] e_status;
    logic [31:0] e_cause;
    logic [31:0] e_epc;
    logic [31:0] e_badv;
  } vec_t;

  vec_t vt[15];

  function automatic vec_t mk(
    input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
    input logic [4:0] raddr, input logic exc, input logic [31:0] etype,
    input logic [31:0] pc, input logic ds, input logic [31:0] bad,
    input logic [31:0] e_rdata, input logic [31:0] e_status,
    input logic [31:0] e_cause, input logic [31:0] e_epc,
    input logic [31:0] e_badv);
    vec_t v;
    v.we = we; v.waddr = waddr; v.wdata = wdata; v.raddr = raddr;
    v.exc = exc; v.etype = etype; v.pc = pc; v.ds = ds; v.bad = bad;
    v.e_rdata = e_rdata; v.e_status = e_status; v.e_cause = e_cause;
    v.e_epc = e_epc; v.e_badv = e_badv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.we_i = 1'b0; bus.waddr_i = 5'd0; bus.wdata_i = 32'd0;
    bus.raddr_i = REG_STATUS; bus.int_i = 6'd0; bus.is_except_i = 1'b0;
    bus.except_type_i = 32'd0; bus.pc_i = 32'd0;
    bus.is_in_delayslot_i = 1'b0; bus.bad_addr_i = 32'd0;
  endtask

  task automatic drive(input vec_t v);
    bus.we_i = v.we; bus.waddr_i = v.waddr; bus.wdata_i = v.wdata;
    bus.raddr_i = v.raddr; bus.is_except_i = v.exc;
    bus.except_type_i = v.etype; bus.pc_i = v.pc;
    bus.is_in_delayslot_i = v.ds; bus.bad_addr_i = v.bad;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    bit early;
    //        we waddr         wdata          raddr         exc type      pc             ds bad          rdata          status         cause          epc            badv
    vt[0]  = mk(0, 5'd0,        32'h0,         REG_STATUS,   0, 32'h0,     32'h0,         0, 32'h0,       32'h0040_0000, 32'h0040_0000, 32'h0000_0000, 32'h0,         32'h0);
    vt[1]  = mk(1, REG_STATUS,  32'hFFFF_FFFF, REG_STATUS,   0, 32'h0,     32'h0,         0, 32'h0,       32'h0040_FF03, 32'h0040_FF03, 32'h0000_0000, 32'h0,         32'h0);
    vt[2]  = mk(1, REG_CAUSE,   32'hFFFF_FFFF, REG_CAUSE,    0, 32'h0,     32'h0,         0, 32'h0,       32'h0000_0300, 32'h0040_FF03, 32'h0000_0300, 32'h0,         32'h0);
    vt[3]  = mk(1, REG_STATUS,  32'h0,         REG_PRID,     0, 32'h0,     32'h0,         0, 32'h0,       32'h004C_0001, 32'h0040_0000, 32'h0000_0300, 32'h0,         32'h0);
    vt[4]  = mk(1, REG_BADVADDR,32'h1234,      REG_BADVADDR, 0, 32'h0,     32'h0,         0, 32'h0,       32'h0,         32'h0040_0000, 32'h0000_0300, 32'h0,         32'h0);
    vt[5]  = mk(0, 5'd0,        32'h0,         REG_EPC,      1, EXC_ADES,  32'hBFC0_0100, 1, 32'h3,       32'h0,         32'h0040_0002, 32'h8000_0314, 32'hBFC0_00FC, 32'h3);
    vt[6]  = mk(0, 5'd0,        32'h0,         REG_CAUSE,    1, EXC_SYS,   32'hBFC0_0200, 0, 32'h0,       32'h8000_0314, 32'h0040_0002, 32'h8000_0320, 32'hBFC0_00FC, 32'h3);
    vt[7]  = mk(0, 5'd0,        32'h0,         REG_STATUS,   1, EXC_ERET,  32'h0,         0, 32'h0,       32'h0040_0002, 32'h0040_0000, 32'h8000_0320, 32'hBFC0_00FC, 32'h3);
    vt[8]  = mk(1, REG_EPC,     32'h1234_5678, REG_EPC,      1, EXC_OV,    32'hBFC0_0300, 0, 32'h0,       32'hBFC0_00FC, 32'h0040_0002, 32'h0000_0330, 32'hBFC0_0300, 32'h3);
    vt[9]  = mk(0, 5'd0,        32'h0,         REG_CONFIG,   1, EXC_ERET,  32'h0,         0, 32'h0,       32'h8000_0000, 32'h0040_0000, 32'h0000_0330, 32'hBFC0_0300, 32'h3);
    vt[10] = mk(1, REG_STATUS,  32'hFFFF_FFFF, REG_STATUS,   1, 32'h3,     32'h0,         0, 32'h0,       32'h0040_0000, 32'h0040_0000, 32'h0000_0330, 32'hBFC0_0300, 32'h3);
    vt[11] = mk(0, 5'd0,        32'h0,         5'd3,         1, EXC_INT,   32'h8000_0010, 0, 32'h0,       32'h0,         32'h0040_0002, 32'h0000_0300, 32'h8000_0010, 32'h3);
    vt[12] = mk(1, REG_EPC,     32'hAAAA_0000, REG_EPC,      1, EXC_ERET,  32'h0,         0, 32'h0,       32'h8000_0010, 32'h0040_0000, 32'h0000_0300, 32'h8000_0010, 32'h3);
    vt[13] = mk(1, REG_EPC,     32'hDEAD_BEEF, REG_EPC,      0, 32'h0,     32'h0,         0, 32'h0,       32'hDEAD_BEEF, 32'h0040_0000, 32'h0000_0300, 32'hDEAD_BEEF, 32'h3);
    vt[14] = mk(0, 5'd0,        32'h0,         REG_EPC,      1, EXC_ADEL,  32'h0000_0040, 0, 32'h0000_1001, 32'hDEAD_BEEF, 32'h0040_0002, 32'h0000_0310, 32'h0000_0040, 32'h0000_1001);

    idle();
    #12;
    chk("reset_status", bus.status_o, 32'h0040_0000);
    chk("reset_cause", bus.cause_o, 32'h0);
    chk("reset_count", bus.count_o, 32'h0);
    chk("reset_timer_int", {31'd0, bus.timer_int_o}, 32'h0);
    chk("reset_rdata", bus.rdata_o, 32'h0040_0000);
    resetn = 1'b1;
    step();

    for (int i = 0; i < 15; i++) begin
      drive(vt[i]);
      #1;
      chk($sformatf("v%0d_rdata", i), bus.rdata_o, vt[i].e_rdata);
      step();
      chk($sformatf("v%0d_status", i), bus.status_o, vt[i].e_status);
      chk($sformatf("v%0d_cause", i), bus.cause_o, vt[i].e_cause);
      chk($sformatf("v%0d_epc", i), bus.epc_o, vt[i].e_epc);
      chk($sformatf("v%0d_badvaddr", i), bus.badvaddr_o, vt[i].e_badv);
    end
    idle();

    // Interrupt lines reach Cause.IP one cycle later
    bus.int_i = 6'b100101;
    #1;
    chk("ip_before_edge", {26'd0, bus.cause_o[15:10]}, 32'h0);
    step();
    chk("ip_sampled", {26'd0, bus.cause_o[15:10]}, 32'h25);
    bus.int_i = 6'd0;
    step();
    chk("ip_cleared", {26'd0, bus.cause_o[15:10]}, 32'h0);

    // Async reset mid-run with Count=0x55
    bus.we_i = 1'b1; bus.waddr_i = REG_COUNT; bus.wdata_i = 32'h55;
    step();
    idle();
    chk("count_written", bus.count_o, 32'h55);
    #2 resetn = 1'b0;
    #1;
    chk("arst_status", bus.status_o, 32'h0040_0000);
    chk("arst_cause", bus.cause_o, 32'h0);
    chk("arst_epc", bus.epc_o, 32'h0);
    chk("arst_badvaddr", bus.badvaddr_o, 32'h0);
    chk("arst_count", bus.count_o, 32'h0);
    chk("arst_compare", bus.compare_o, 32'h0);
    chk("arst_rdata", bus.rdata_o, 32'h0040_0000);
    #3 resetn = 1'b1;
    step();

    // Timer: Compare=0x10, interrupt one cycle after Count reaches it
    bus.we_i = 1'b1; bus.waddr_i = REG_COMPARE; bus.wdata_i = 32'h10;
    step();
    idle();
    chk("compare_written", bus.compare_o, 32'h10);
    seen = 1'b0;
    early = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      if (bus.timer_int_o !== 1'b0) early = 1'b1;
      if (bus.count_o == 32'h10) seen = 1'b1;
      else step();
    end
    chk("timer_reached_compare", {31'd0, seen}, 32'h1);
    chk("timer_no_early_int", {31'd0, early}, 32'h0);
    step();
`ifdef CP0_TIMER_INT_EN
    chk("timer_int_set", {31'd0, bus.timer_int_o}, 32'h1);
    step();
    chk("cause_ip7_timer", {31'd0, bus.cause_o[15]}, 32'h1);
`else
    chk("timer_int_tied0", {31'd0, bus.timer_int_o}, 32'h0);
    step();
    chk("cause_ip7_no_timer", {31'd0, bus.cause_o[15]}, 32'h0);
`endif
    bus.we_i = 1'b1; bus.waddr_i = REG_COMPARE; bus.wdata_i = 32'h40;
    step();
    idle();
    chk("timer_int_cleared", {31'd0, bus.timer_int_o}, 32'h0);

    // Count wrap and MFC0 Count bypass
    bus.we_i = 1'b1; bus.waddr_i = REG_COUNT; bus.wdata_i = 32'hFFFF_FFFF;
    bus.raddr_i = REG_COUNT;
    #1;
    chk("count_bypass", bus.rdata_o, 32'hFFFF_FFFF);
    step();
    idle();
    chk("count_max", bus.count_o, 32'hFFFF_FFFF);
    @(posedge clk);
    step();
    chk("count_wrap", bus.count_o, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
